wb_mem_ctrl: RTL

WB_MEM_CTRL -- requirements
Module: wb_mem_ctrl

---
 rtl/wb_mem_ctrl_pkg.sv | 11 +
 rtl/wb_addr_decode.sv | 29 ++
 rtl/wb_mem_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_mem_ctrl_pkg.sv
// rtl/wb_mem_ctrl_pkg.sv - shared types and address map for the wishbone memory controller
package wb_mem_ctrl_pkg;

  typedef enum logic {ST_IDLE, ST_WAIT_ACK} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_ROM, SEL_RAM, SEL_IO} sel_t;

  localparam logic [31:0] MAP_MASK = 32'hffff_8000;
  localparam logic [31:0] ROM_BASE = 32'hb000_0000;
  localparam logic [31:0] RAM_BASE = 32'hb000_8000;

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational address decode to slave select plus access error
module wb_addr_decode
  import wb_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'hc000_0000
) (
  input  logic [31:0] i_addr,
  input  logic        i_we,
  output sel_t        o_sel,
  output logic        o_err
);

  always_comb begin
    o_sel = SEL_NONE;
    o_err = 1'b0;
    if ((i_addr & MAP_MASK) == ROM_BASE) begin
      // rom is read-only: a write is an access error, not a strobe
      if (i_we) o_err = 1'b1;
      else      o_sel = SEL_ROM;
    end else if ((i_addr & MAP_MASK) == RAM_BASE) begin
      o_sel = SEL_RAM;
    end else if (i_addr == IO_BASE) begin
      o_sel = SEL_IO;
    end else begin
      o_err = 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_ctrl.sv
// rtl/wb_mem_ctrl.sv - single-outstanding wishbone interconnect to rom/ram/io with timeout
module wb_mem_ctrl
  import wb_mem_ctrl_pkg::*;
#(
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] IO_BASE = 32'hc000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_exception,
  output logic [31:0] o_slv_addr,
  output logic [31:0] o_slv_data,
  output logic        o_slv_we,
  output logic        o_rom_stb,
  input  logic        i_rom_stall,
  input  logic        i_rom_ack,
  input  logic [31:0] i_rom_data,
  output logic        o_ram_stb,
  input  logic        i_ram_stall,
  input  logic        i_ram_ack,
  input  logic [31:0] i_ram_data,
  output logic        o_io_stb,
  input  logic        i_io_stall,
  input  logic        i_io_ack,
  input  logic [31:0] i_io_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  sel_t          r_sel;
  logic [CW-1:0] r_cnt;
  logic          r_exception;

  sel_t          w_sel;
  logic          w_err;
  logic          w_req;
  logic          w_wait;
  logic          w_sel_stall;
  logic          w_lat_ack;
  logic [31:0]   w_lat_data;
  logic          w_accept;

  wb_addr_decode #(.IO_BASE(IO_BASE)) u_decode (
    .i_addr (i_addr),
    .i_we   (i_we),
    .o_sel  (w_sel),
    .o_err  (w_err)
  );

  // outputs are masked while reset is held so nothing leaks from an abandoned transfer
  assign w_req  = i_wb_cyc & i_wb_stb & (r_state == ST_IDLE) & ~reset;
  assign w_wait = (r_state == ST_WAIT_ACK) & ~reset;

  always_comb begin
    w_sel_stall = 1'b0;
    case (w_sel)
      SEL_ROM: w_sel_stall = i_rom_stall;
      SEL_RAM: w_sel_stall = i_ram_stall;
      SEL_IO:  w_sel_stall = i_io_stall;
      default: w_sel_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_lat_ack  = 1'b0;
    w_lat_data = 32'h0;
    case (r_sel)
      SEL_ROM: begin w_lat_ack = i_rom_ack; w_lat_data = i_rom_data; end
      SEL_RAM: begin w_lat_ack = i_ram_ack; w_lat_data = i_ram_data; end
      SEL_IO:  begin w_lat_ack = i_io_ack;  w_lat_data = i_io_data;  end
      default: begin w_lat_ack = 1'b0;      w_lat_data = 32'h0;      end
    endcase
  end

  assign w_accept = w_req & (w_sel != SEL_NONE) & ~w_sel_stall;

  assign o_rom_stb   = w_req & (w_sel == SEL_ROM);
  assign o_ram_stb   = w_req & (w_sel == SEL_RAM);
  assign o_io_stb    = w_req & (w_sel == SEL_IO);
  assign o_wb_stall  = w_wait | (w_req & w_sel_stall);
  assign o_wb_ack    = w_wait & i_wb_cyc & w_lat_ack;
  assign o_data      = w_wait ? w_lat_data : 32'h0;
  assign o_exception = r_exception;
  assign o_slv_addr  = i_addr;
  assign o_slv_data  = i_data;
  assign o_slv_we    = i_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_NONE;
      r_cnt       <= '0;
      r_exception <= 1'b0;
    end else begin
      r_exception <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel   <= w_sel;
            r_cnt   <= '0;
            r_state <= ST_WAIT_ACK;
          end else if (w_req & w_err) begin
            r_exception <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // abort and ack both take priority over the timeout check
          if (!i_wb_cyc || w_lat_ack) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_NONE;
          end else begin
            if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + CW'(1);
            if (r_cnt >= CW'(TIMEOUT - 1)) begin
              r_exception <= 1'b1;
              r_state     <= ST_IDLE;
              r_sel       <= SEL_NONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
